// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Round-robin arbiter sharing one 8-bit UART transmitter among
//            NUM_REQ byte requesters; line config applied only between frames.
// Revision : 1.0
// ============================================================================

module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 4,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_gnt,
    output logic [NUM_REQ-1:0]   req_done,
    input  logic                 cfg_we,
    input  logic [7:0]           cfg_wdata,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic [1:0]           tx_wls,
    output logic                 tx_stb,
    output logic                 tx_pen,
    output logic                 tx_eps,
    output logic                 tx_sp,
    output logic                 tx_bc,
    output logic [2:0]           active_id,
    output logic                 sched_busy,
    output logic                 err_timeout
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int TCW = $clog2(BUSY_TIMEOUT + 1);
    localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [6:0] CFG_RESET = 7'h07;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LAUNCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    logic [2:0]     state_q,   state_d;
    logic [6:0]     shadow_q,  shadow_d;
    logic           pending_q, pending_d;
    logic [6:0]     live_q,    live_d;
    logic [IDW-1:0] rr_q,      rr_d;
    logic [IDW-1:0] id_q,      id_d;
    logic [7:0]     data_q,    data_d;
    logic [TCW-1:0] tcnt_q,    tcnt_d;
    logic [GCW-1:0] gcnt_q,    gcnt_d;

    logic           sel_found;
    logic [IDW-1:0] sel_idx;
    logic           grant;
    logic           between;
    logic           timed_out;
    logic           unused_cfg_bit7;

    assign unused_cfg_bit7 = cfg_wdata[7];

    // First valid requester after the last one served, wrapping around.
    always_comb begin
        int             cand;
        logic [IDW-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(rr_q) + k) % NUM_REQ;
            cand_idx = IDW'(cand);
            if (!sel_found && req_valid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // Break holds the line, so nothing may be launched while it is set.
    assign grant     = rst_n && (state_q == ST_IDLE) && !live_q[6] && sel_found;
    assign timed_out = !tx_busy && (tcnt_q == TCW'(BUSY_TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shadow_q  <= CFG_RESET;
            pending_q <= 1'b0;
            live_q    <= CFG_RESET;
            rr_q      <= IDW'(NUM_REQ - 1);
            id_q      <= '0;
            data_q    <= '0;
            tcnt_q    <= '0;
            gcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            live_q    <= live_d;
            rr_q      <= rr_d;
            id_q      <= id_d;
            data_q    <= data_d;
            tcnt_q    <= tcnt_d;
            gcnt_q    <= gcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        data_d  = data_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    rr_d    = sel_idx;
                    id_d    = sel_idx;
                    data_d  = req_data[{sel_idx, 3'b000} +: 8];
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tcnt_d  = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timed_out) begin
                    gcnt_d  = GCW'(GAP_CYCLES);
                    state_d = ST_GAP;
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    gcnt_d  = GCW'(GAP_CYCLES);
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // A zero-length gap still occupies one cycle.
                if (gcnt_q <= GCW'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q - GCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Live config follows the shadow whenever we are, or are about to be,
        // between frames, so a write lands on the first idle/gap cycle.
        between   = (state_q == ST_IDLE) || (state_q == ST_GAP) ||
                    (state_d == ST_IDLE) || (state_d == ST_GAP);
        shadow_d  = cfg_we ? cfg_wdata[6:0] : shadow_q;
        pending_d = pending_q | cfg_we;
        live_d    = live_q;
        if (between && pending_d) begin
            live_d    = shadow_d;
            pending_d = 1'b0;
        end
    end

    always_comb begin
        req_gnt     = '0;
        req_done    = '0;
        tx_start    = 1'b0;
        err_timeout = 1'b0;
        sched_busy  = (state_q != ST_IDLE);
        if (grant) begin
            req_gnt[sel_idx] = 1'b1;
        end
        case (state_q)
            ST_LAUNCH:    tx_start    = 1'b1;
            ST_WAIT_BUSY: err_timeout = rst_n && timed_out;
            ST_WAIT_DONE: begin
                if (rst_n && tx_done) begin
                    req_done[id_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign tx_data   = data_q;
    assign tx_wls    = live_q[1:0];
    assign tx_stb    = live_q[2];
    assign tx_pen    = live_q[3];
    assign tx_eps    = live_q[4];
    assign tx_sp     = live_q[5];
    assign tx_bc     = live_q[6];
    assign active_id = 3'(id_q);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Purpose  : Directed self-checking bench for uart_tx_scheduler.
// Revision : 1.0
// ============================================================================

module tb_uart_tx_scheduler;

    localparam int NUM_REQ = 4;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_gnt;
    logic [NUM_REQ-1:0]   req_done;
    logic                 cfg_we;
    logic [7:0]           cfg_wdata;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic [1:0]           tx_wls;
    logic                 tx_stb, tx_pen, tx_eps, tx_sp, tx_bc;
    logic [2:0]           active_id;
    logic                 sched_busy;
    logic                 err_timeout;
    logic [6:0]           cfg_live;

    int n_checks = 0;
    int n_fails  = 0;

    uart_tx_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .BUSY_TIMEOUT (4),
        .GAP_CYCLES   (1)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_gnt     (req_gnt),
        .req_done    (req_done),
        .cfg_we      (cfg_we),
        .cfg_wdata   (cfg_wdata),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_wls      (tx_wls),
        .tx_stb      (tx_stb),
        .tx_pen      (tx_pen),
        .tx_eps      (tx_eps),
        .tx_sp       (tx_sp),
        .tx_bc       (tx_bc),
        .active_id   (active_id),
        .sched_busy  (sched_busy),
        .err_timeout (err_timeout)
    );

    assign cfg_live = {tx_bc, tx_sp, tx_eps, tx_pen, tx_stb, tx_wls};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = 32'h44332211;
        cfg_we    = 1'b0;
        cfg_wdata = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    // Full frame starting in an IDLE cycle whose req_valid is already driven.
    task automatic serve(input int id, input logic [7:0] b);
        #1;
        check("serve_gnt", 32'(req_gnt), 32'(1 << id));
        check("serve_idle", 32'(sched_busy), 32'd0);
        cyc();
        #1;
        check("serve_start", 32'(tx_start), 32'd1);
        check("serve_data", 32'(tx_data), 32'(b));
        check("serve_active", 32'(active_id), 32'(id));
        check("serve_one_gnt", 32'(req_gnt), 32'd0);
        cyc();
        tx_busy = 1'b1;
        cyc();
        repeat (3) cyc();
        tx_busy = 1'b0;
        tx_done = 1'b1;
        #1;
        check("serve_done", 32'(req_done), 32'(1 << id));
        cyc();
        tx_done = 1'b0;
        #1;
        check("serve_gap_busy", 32'(sched_busy), 32'd1);
        check("serve_gap_done", 32'(req_done), 32'd0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        do_reset();
        #1;
        check("rst_cfg", 32'(cfg_live), 32'h07);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_busy", 32'(sched_busy), 32'd0);
        check("rst_gnt", 32'(req_gnt), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_active", 32'(active_id), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);

        // Single frame from requester 0, busy at T+3, done ten cycles later
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        #1;
        check("t1_gnt", 32'(req_gnt), 32'h1);
        check("t1_no_start", 32'(tx_start), 32'd0);
        cyc();
        req_valid = '0;
        #1;
        check("t1_start", 32'(tx_start), 32'd1);
        check("t1_data", 32'(tx_data), 32'hA5);
        check("t1_sched_busy", 32'(sched_busy), 32'd1);
        cyc();
        #1;
        check("t1_start_once", 32'(tx_start), 32'd0);
        cyc();
        tx_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            #1;
            check("t1_no_early_done", 32'(req_done), 32'd0);
        end
        cyc();
        tx_busy = 1'b0;
        tx_done = 1'b1;
        #1;
        check("t1_done", 32'(req_done), 32'h1);
        cyc();
        tx_done = 1'b0;
        #1;
        check("t1_gap", 32'(sched_busy), 32'd1);
        cyc();
        #1;
        check("t1_idle", 32'(sched_busy), 32'd0);
        req_data[7:0] = 8'h11;

        // Round robin with every requester pending
        do_reset();
        req_valid = 4'b1111;
        serve(0, 8'h11);
        serve(1, 8'h22);
        serve(2, 8'h33);
        serve(3, 8'h44);
        serve(0, 8'h11);

        // Busy never arrives: timeout four cycles after WAIT_BUSY entry
        req_valid = 4'b0100;
        #1;
        check("t3_gnt", 32'(req_gnt), 32'h4);
        cyc();
        req_valid = '0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_no_err_yet", 32'(err_timeout), 32'd0);
            cyc();
        end
        #1;
        check("t3_err", 32'(err_timeout), 32'd1);
        check("t3_no_done", 32'(req_done), 32'd0);
        cyc();
        req_valid = 4'b1000;
        #1;
        check("t3_err_pulse", 32'(err_timeout), 32'd0);
        check("t3_gap_no_gnt", 32'(req_gnt), 32'd0);
        cyc();
        serve(3, 8'h44);

        // Config written mid-frame is held until the gap
        req_valid = 4'b0001;
        #1;
        check("t4_gnt", 32'(req_gnt), 32'h1);
        cyc();
        req_valid = '0;
        cyc();
        tx_busy = 1'b1;
        cyc();
        cfg_we    = 1'b1;
        cfg_wdata = 8'h1B;
        #1;
        check("t4_cfg_hold0", 32'(cfg_live), 32'h07);
        cyc();
        cfg_we = 1'b0;
        #1;
        check("t4_cfg_hold1", 32'(cfg_live), 32'h07);
        cyc();
        tx_busy = 1'b0;
        tx_done = 1'b1;
        #1;
        check("t4_cfg_hold_done", 32'(cfg_live), 32'h07);
        check("t4_done", 32'(req_done), 32'h1);
        cyc();
        tx_done = 1'b0;
        #1;
        check("t4_cfg_applied", 32'(cfg_live), 32'h1B);
        cyc();

        // Break suppresses grants; clearing it lets them resume
        cfg_we    = 1'b1;
        cfg_wdata = 8'h5B;
        #1;
        check("t5_bc_before", 32'(tx_bc), 32'd0);
        cyc();
        cfg_we    = 1'b0;
        req_valid = 4'b0010;
        #1;
        check("t5_bc_set", 32'(cfg_live), 32'h5B);
        check("t5_no_gnt0", 32'(req_gnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            check("t5_no_gnt", 32'(req_gnt), 32'd0);
            check("t5_stay_idle", 32'(sched_busy), 32'd0);
        end
        cyc();
        cfg_we    = 1'b1;
        cfg_wdata = 8'h07;
        #1;
        check("t5_no_gnt_wr", 32'(req_gnt), 32'd0);
        cyc();
        cfg_we = 1'b0;
        #1;
        check("t5_bc_clear", 32'(cfg_live), 32'h07);
        serve(1, 8'h22);

        // Reset mid-frame drops the in-flight requester silently
        req_valid = 4'b0100;
        #1;
        check("t6_gnt", 32'(req_gnt), 32'h4);
        cyc();
        req_valid = '0;
        cyc();
        tx_busy = 1'b1;
        cyc();
        rst_n = 1'b0;
        #1;
        check("t6_wait_done", 32'(sched_busy), 32'd1);
        cyc();
        #1;
        check("t6_rst_busy", 32'(sched_busy), 32'd0);
        check("t6_rst_data", 32'(tx_data), 32'd0);
        check("t6_rst_active", 32'(active_id), 32'd0);
        check("t6_rst_start", 32'(tx_start), 32'd0);
        check("t6_rst_cfg", 32'(cfg_live), 32'h07);
        rst_n   = 1'b1;
        tx_done = 1'b1;
        #1;
        check("t6_late_done", 32'(req_done), 32'd0);
        cyc();
        tx_done = 1'b0;
        tx_busy = 1'b0;
        #1;
        check("t6_after_done", 32'(req_done), 32'd0);
        check("t6_after_start", 32'(tx_start), 32'd0);
        check("t6_after_busy", 32'(sched_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
